// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter and related peripherals.
//   arb_state       : arbiter FSM state encoding
//   UART_BYTE_W     : width of one transmit byte
//   HOLD_CYCLES_DEF : default mid-packet idle limit before a forced release
//   cnt_width()     : width of a saturating counter that must reach 'hold'
package uart_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state;

    localparam int UART_BYTE_W     = 8;
    localparam int HOLD_CYCLES_DEF = 1024;

    // A hold limit of 0 disables the timeout; keep a 1-bit counter so the
    // logic still elaborates.
    function automatic int cnt_width(input int hold);
        return (hold == 0) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, reusable by any shared-peripheral
// arbiter.
//   i_req        : request vector, one bit per requester
//   i_last_grant : index of the previous owner; search starts one above it
//   o_grant      : winning index (0 when nothing is requested)
//   o_any        : at least one request is present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [GW-1:0]   i_last_grant,
    output logic [GW-1:0]   o_grant,
    output logic            o_any
);

    logic [GW-1:0] w_idx;

    // Walk from the farthest candidate back to the nearest so the requester
    // closest after the last owner is the final (winning) assignment.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_idx = GW'((int'(i_last_grant) + off) % NREQ);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-locked round-robin arbiter sharing one UART transmit
// byte stream among NREQ producers, with a one-entry registered output stage.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ARB_IDLE   | no owner; pick the next requester round-robin
//   ARB_LOCKED | owner r_grant_id streams bytes until last byte or timeout
//
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_req_valid/_data/_last  : per-requester byte offer (data at [8i+7:8i])
//   o_req_ready              : per-requester byte accepted this cycle
//   o_tx_valid/_data         : byte presented to the UART transmitter
//   i_tx_ready               : transmitter takes o_tx_data this cycle
//   o_grant_id               : current or most recent owner
//   o_busy                   : grant held
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int GW          = $clog2(NREQ)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NREQ-1:0]             i_req_valid,
    input  logic [NREQ*UART_BYTE_W-1:0] i_req_data,
    input  logic [NREQ-1:0]             i_req_last,
    output logic [NREQ-1:0]             o_req_ready,
    output logic                        o_tx_valid,
    output logic [UART_BYTE_W-1:0]      o_tx_data,
    input  logic                        i_tx_ready,
    output logic [GW-1:0]               o_grant_id,
    output logic                        o_busy
);

    localparam int             CNT_W    = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

    arb_state                r_state;
    logic [GW-1:0]           r_grant_id;
    logic [GW-1:0]           r_last_grant;
    logic [CNT_W-1:0]        r_idle_cnt;
    logic                    r_tx_valid;
    logic [UART_BYTE_W-1:0]  r_tx_data;

    logic [GW-1:0]           w_pick;
    logic                    w_any;
    logic                    w_locked;
    logic                    w_slot_free;
    logic                    w_valid_g;
    logic                    w_last_g;
    logic [UART_BYTE_W-1:0]  w_data_g;
    logic                    w_accept;
    logic [CNT_W-1:0]        w_idle_next;
    logic                    w_expire;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick),
        .o_any        (w_any)
    );

    assign w_locked    = (r_state == ARB_LOCKED);
    // The output register can take a byte when empty or draining this cycle.
    assign w_slot_free = ~r_tx_valid | i_tx_ready;
    assign w_valid_g   = i_req_valid[r_grant_id];
    assign w_last_g    = i_req_last[r_grant_id];
    assign w_data_g    = i_req_data[r_grant_id*UART_BYTE_W +: UART_BYTE_W];
    assign w_accept    = w_locked & w_slot_free & w_valid_g;

    always_comb begin
        o_req_ready = '0;
        if (w_locked && w_slot_free) begin
            o_req_ready[r_grant_id] = 1'b1;
        end
    end

    // Idle counter only advances while the owner offers nothing; a stalled
    // owner blocked by backpressure is not counted as idle.
    always_comb begin
        w_idle_next = r_idle_cnt;
        if (w_accept) begin
            w_idle_next = '0;
        end else if (!w_valid_g && (r_idle_cnt != HOLD_VAL)) begin
            w_idle_next = r_idle_cnt + 1'b1;
        end
    end

    // An accepted byte clears the count, so a last byte arriving on the
    // would-be expiry cycle releases only through the last-byte path.
    assign w_expire = (HOLD_CYCLES != 0) && w_locked && !w_accept &&
                      (w_idle_next == HOLD_VAL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NREQ - 1);
            r_idle_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_any) begin
                        r_grant_id <= w_pick;
                        r_state    <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    r_idle_cnt <= w_idle_next;
                    if ((w_accept && w_last_g) || w_expire) begin
                        r_last_grant <= r_grant_id;
                        r_state      <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Output stage runs independently of the FSM so a held byte drains
    // across a release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_data_g;
        end else if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant_id;
    assign o_busy     = w_locked;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb[$];
    logic [7:0] mon_exp;
    logic [8:0] pmem [4][16];
    int         head [4];
    int         tail [4];

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NREQ        (4),
        .HOLD_CYCLES (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_grant_id  (grant_id),
        .o_busy      (busy)
    );

    // Scoreboard monitor: every byte the transmitter takes must be the next
    // expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL tx_unexpected: got byte %02h, expected none", tx_data);
            end else begin
                mon_exp = sb.pop_front();
                if (tx_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_byte: got %02h, expected %02h", tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = pmem[i][head[i]][7:0];
                req_last[i]        = pmem[i][head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        pmem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    // One clock: sample acceptances and grant legality before the edge,
    // advance producers after it.
    task automatic tick();
        logic [3:0] acc;
        logic [3:0] allowed;
        @(negedge clk);
        acc     = req_valid & req_ready;
        allowed = busy ? (4'b0001 << grant_id) : 4'b0000;
        chk("ready_legal", {28'd0, req_ready & ~allowed}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) head[i]++;
        end
        drive();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        drive();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || tx_valid || busy) && k < 60) begin
            tick();
            k++;
        end
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_grant", {30'd0, grant_id}, 0);

        // Two requesters, req0 first then req2 after one idle cycle
        reset_dut();
        push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
        push(2, 8'h61, 0); push(2, 8'h62, 1);
        sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
        sb.push_back(8'h61); sb.push_back(8'h62);
        drive();
        tick();
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_grant0", {30'd0, grant_id}, 0);
        chk("t1_ready0", {28'd0, req_ready}, 32'h1);
        tick(); tick(); tick();
        chk("t1_idle_busy", {31'd0, busy}, 0);
        chk("t1_dead_ready", {28'd0, req_ready}, 0);
        tick();
        chk("t1_grant2", {30'd0, grant_id}, 2);
        chk("t1_ready2", {28'd0, req_ready}, 32'h4);
        drain("t1");

        // All four valid, single-byte packets: strict rotation
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                push(i, 8'(8'h80 + 16 * i + k), 1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                sb.push_back(8'(8'h80 + 16 * i + k));
            end
        end
        drive();
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("t2_rr_grant", {30'd0, grant_id}, j % 4);
            tick();
        end
        drain("t2");

        // Backpressure holds data and blocks the owner
        reset_dut();
        tx_ready = 1'b0;
        push(1, 8'hC1, 0); push(1, 8'hC2, 0); push(1, 8'hC3, 1);
        sb.push_back(8'hC1); sb.push_back(8'hC2); sb.push_back(8'hC3);
        drive();
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_hold_data", {24'd0, tx_data}, 32'hC1);
            chk("t3_hold_valid", {31'd0, tx_valid}, 1);
            chk("t3_hold_ready", {28'd0, req_ready}, 0);
        end
        tx_ready = 1'b1;
        #1;
        chk("t3_resume_ready", {28'd0, req_ready}, 32'h2);
        tick();
        chk("t3_next_byte", {24'd0, tx_data}, 32'hC2);
        drain("t3");

        // Timeout: req1 stalls mid-packet, req3 takes over
        reset_dut();
        push(1, 8'h10, 0);
        push(3, 8'h30, 1);
        sb.push_back(8'h10); sb.push_back(8'h30);
        sb.push_back(8'h11); sb.push_back(8'h12);
        drive();
        tick();
        chk("t4_grant1", {30'd0, grant_id}, 1);
        tick();
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk("t4_still_busy", {31'd0, busy}, 1);
        end
        tick();
        chk("t4_timeout_busy", {31'd0, busy}, 0);
        chk("t4_timeout_ready", {28'd0, req_ready}, 0);
        push(1, 8'h11, 0); push(1, 8'h12, 1);
        drive();
        tick();
        chk("t4_grant3", {30'd0, grant_id}, 3);
        tick();
        tick();
        chk("t4_regrant1", {30'd0, grant_id}, 1);
        drain("t4");

        // Last byte on the would-be expiry cycle
        reset_dut();
        push(2, 8'h20, 0);
        push(3, 8'h3A, 1);
        sb.push_back(8'h20); sb.push_back(8'h21); sb.push_back(8'h3A);
        drive();
        tick();
        chk("t5_grant2", {30'd0, grant_id}, 2);
        for (int k = 2; k <= 9; k++) tick();
        chk("t5_busy_before", {31'd0, busy}, 1);
        push(2, 8'h21, 1);
        drive();
        tick();
        chk("t5_released", {31'd0, busy}, 0);
        chk("t5_dead_ready", {28'd0, req_ready}, 0);
        tick();
        chk("t5_grant3", {30'd0, grant_id}, 3);
        chk("t5_busy3", {31'd0, busy}, 1);
        drain("t5");

        // Reset mid-packet
        reset_dut();
        push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 0);
        push(0, 8'h54, 0); push(0, 8'h55, 1);
        sb.push_back(8'h51);
        drive();
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_tx_valid", {31'd0, tx_valid}, 0);
        chk("t6_tx_data", {24'd0, tx_data}, 0);
        chk("t6_req_ready", {28'd0, req_ready}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_grant", {30'd0, grant_id}, 0);
        chk("t6_sb_before", sb.size(), 0);
        reset_dut();
        push(2, 8'h62, 1);
        push(0, 8'h60, 1);
        sb.push_back(8'h60); sb.push_back(8'h62);
        drive();
        tick();
        chk("t6_grant0_again", {30'd0, grant_id}, 0);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
